down_counter_timer: RTL and testbench

- Presettable synchronous down-counter/timer. It is the decrementing counterpart of the 74161-style up-counter used in the CPU model.
- Loaded with a count, it decrements on each enabled clock and flags expiry at zero.
- Cascade pins (enp/ent/bo) mirror the up-counter's ENP/ENT/RCO, so stages chain into wider timers.
- Used for delay/wait-state timing next to the program-counter chain.

---
 rtl/down_counter_timer.sv | 104 ++++++++++
 tb/tb_down_counter_timer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Presettable synchronous down-counter/timer with ENP/ENT/BO cascade pins.
// Optional macro DOWN_COUNTER_TIMER_AUTORELOAD_EN turns it into a periodic ticker.
module down_counter_timer #(
  parameter int WIDTH   = 8,
  parameter int T_CLK2Q = 15,
  parameter int T_BO    = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic             bo,
  output logic             running,
  output logic             expired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EXP  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Timing figures describe the board-level part; the RTL is zero-delay.
  if (WIDTH < 2 || T_CLK2Q < 0 || T_BO < 0) begin : g_bad_param
    $error("down_counter_timer: WIDTH must be >= 2, delays >= 0");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             expired_q, expired_d;
  logic             cnt_en;
  logic             at_one;

`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Count only in RUN with both enables and no load this edge.
  assign cnt_en = load_n & enp & ent & (state_q == S_RUN);
  assign at_one = (q_q == ONE);

  // Next state: load beats count beats hold (clr handled in the register).
  always_comb begin
    q_d       = q_q;
    state_d   = state_q;
    expired_d = 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
    reload_d  = reload_q;
`endif
    unique case (1'b1)
      !load_n: begin
        q_d     = P;
        state_d = (P == '0) ? S_EXP : S_RUN;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
        reload_d = P;
`endif
      end
      cnt_en && !at_one: begin
        q_d = q_q - ONE;
      end
      cnt_en && at_one: begin
        expired_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
        q_d       = reload_q;
`else
        q_d       = '0;
        state_d   = S_EXP;
`endif
      end
      default: begin
      end
    endcase
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_q       <= '0;
      state_q   <= S_IDLE;
      expired_q <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      q_q       <= q_d;
      state_q   <= state_d;
      expired_q <= expired_d;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign Q       = q_q;
  assign running = (state_q == S_RUN);
  assign expired = expired_q;
  assign bo      = (q_q == '0) & ent;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: one 8-bit unit plus a
// two-stage 4-bit cascade, all checked against a behavioural model.
module tb_down_counter_timer;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr = 1'b1;
  logic          load_n = 1'b1;
  logic          enp = 1'b0;
  logic          ent = 1'b0;
  logic [W-1:0]  P = '0;
  logic [W-1:0]  Q;
  logic          bo, running, expired;

  logic          lo_load_n = 1'b1;
  logic          hi_load_n = 1'b1;
  logic [CW-1:0] lo_p = '0;
  logic [CW-1:0] hi_p = '0;
  logic [CW-1:0] lo_q, hi_q;
  logic          lo_bo, hi_bo, lo_run, hi_run, lo_exp, hi_exp;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .load_n(load_n), .enp(enp), .ent(ent),
    .P(P), .Q(Q), .bo(bo), .running(running), .expired(expired)
  );

  down_counter_timer #(.WIDTH(CW)) u_lo (
    .clk(clk), .clr(clr), .load_n(lo_load_n), .enp(enp), .ent(ent),
    .P(lo_p), .Q(lo_q), .bo(lo_bo), .running(lo_run), .expired(lo_exp)
  );

  down_counter_timer #(.WIDTH(CW)) u_hi (
    .clk(clk), .clr(clr), .load_n(hi_load_n), .enp(enp), .ent(lo_bo),
    .P(hi_p), .Q(hi_q), .bo(hi_bo), .running(hi_run), .expired(hi_exp)
  );

  typedef struct {
    int q;
    int mode;
    int reload;
    bit exp;
  } mdl_t;

  typedef struct {
    int q;
    bit run;
    bit exp;
    bit bo;
    int lo_q;
    int hi_q;
    bit lo_exp;
    bit hi_exp;
    bit hi_run;
    bit hi_bo;
  } exp_t;

  exp_t sbq[$];
  mdl_t m, ml, mh;
  int   checks = 0;
  int   failures = 0;

  function automatic mdl_t step(mdl_t s, bit c, bit ln, bit ep, bit et,
                                int pv);
    mdl_t r;
    r = s;
    r.exp = 1'b0;
    if (c) begin
      r.q = 0;
      r.mode = M_IDLE;
      r.reload = 0;
    end else if (!ln) begin
      r.q = pv;
      r.reload = pv;
      r.mode = (pv != 0) ? M_RUN : M_DONE;
    end else if (s.mode == M_RUN && ep && et) begin
      if (s.q == 1) begin
        r.exp = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
        r.q = s.reload;
`else
        r.q = 0;
        r.mode = M_DONE;
`endif
      end else begin
        r.q = s.q - 1;
      end
    end
    return r;
  endfunction

  // Drive one cycle of stimulus at a falling edge and queue the result
  // expected after the next rising edge.
  task automatic cyc(bit c, bit ln, bit ep, bit et, int pv);
    exp_t e;
    bit   hi_et;
    clr = c;
    load_n = ln;
    enp = ep;
    ent = et;
    P = W'(pv);
    hi_et = (ml.q == 0) && et;
    m  = step(m, c, ln, ep, et, pv % 256);
    ml = step(ml, c, lo_load_n, ep, et, int'(lo_p));
    mh = step(mh, c, hi_load_n, ep, hi_et, int'(hi_p));
    e.q = m.q;
    e.run = (m.mode == M_RUN);
    e.exp = m.exp;
    e.bo = (m.q == 0) && et;
    e.lo_q = ml.q;
    e.hi_q = mh.q;
    e.lo_exp = ml.exp;
    e.hi_exp = mh.exp;
    e.hi_run = (mh.mode == M_RUN);
    e.hi_bo = (mh.q == 0) && (ml.q == 0) && et;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(string n, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d", n, $time, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("Q", int'(Q), e.q);
        chk("running", int'(running), int'(e.run));
        chk("expired", int'(expired), int'(e.exp));
        chk("bo", int'(bo), int'(e.bo));
        chk("lo_Q", int'(lo_q), e.lo_q);
        chk("hi_Q", int'(hi_q), e.hi_q);
        chk("lo_expired", int'(lo_exp), int'(e.lo_exp));
        chk("hi_expired", int'(hi_exp), int'(e.hi_exp));
        chk("hi_running", int'(hi_run), int'(e.hi_run));
        chk("hi_bo", int'(hi_bo), int'(e.hi_bo));
      end
    end
  end

  initial begin
    int pv;
    m = '{default: 0};
    ml = '{default: 0};
    mh = '{default: 0};
    @(negedge clk);
    // Reset, bo follows ent.
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    // One-shot from 3.
    cyc(0, 0, 1, 1, 3);
    repeat (6) cyc(0, 1, 1, 1, 0);
    // Stall, then count; reload at Q==1.
    cyc(0, 0, 0, 1, 5);
    repeat (4) cyc(0, 1, 0, 1, 0);
    repeat (4) cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 9);
    repeat (8) cyc(0, 1, 1, 1, 0);
    // Clear at Q==1, then idle.
    cyc(1, 1, 1, 1, 0);
    repeat (3) cyc(0, 1, 1, 1, 0);
    // Zero load stays put.
    cyc(0, 0, 1, 1, 0);
    repeat (6) cyc(0, 1, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0);
    // Cascade lo=2, hi=1.
    lo_load_n = 1'b0;
    hi_load_n = 1'b0;
    lo_p = 4'd2;
    hi_p = 4'd1;
    cyc(0, 1, 1, 1, 0);
    lo_load_n = 1'b1;
    hi_load_n = 1'b1;
    repeat (5) cyc(0, 1, 1, 1, 0);
    // Periodic-tick sample.
    cyc(0, 0, 1, 1, 4);
    repeat (10) cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    repeat (3) cyc(0, 1, 1, 1, 0);
    // Random traffic.
    repeat (600) begin
      pv = ($urandom % 3 == 0) ? int'($urandom % 4) : int'($urandom % 256);
      lo_load_n = ($urandom % 10 != 0);
      hi_load_n = ($urandom % 10 != 0);
      lo_p = CW'($urandom % 16);
      hi_p = CW'($urandom % 16);
      cyc(($urandom % 50 == 0), ($urandom % 8 != 0),
          ($urandom % 4 != 0), ($urandom % 4 != 0), pv);
    end
    lo_load_n = 1'b1;
    hi_load_n = 1'b1;
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && sbq.size() != 0; i++) @(posedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
